umstr_st_merger: RTL
====================

Name: umstr_st_merger

Overview:
- Transmit-side counterpart of the receive splitter: merges three AXI-Stream packet sources into the single stream feeding the TSE MAC transmit interface.
- Sources: search-device reply (sd), axi2udp transmit (au), ARP reply (arp).
- Packet-level round-robin arbitration. A grant is held from the first beat to the tlast beat, so packets never interleave.
- Output passes through a registered full-throughput skid stage, so there is no combinational path from the TSE ready back to the source readies.

Parameters:
- T_DATA_WIDTH, 32, tdata width of all ports.
- T_KEEP_WIDTH, 4, tkeep width of all ports (one bit per byte).

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- sd_tdata_i  in  T_DATA_WIDTH  search-device source data.
- sd_tvld_i  in  1  search-device source valid.
- sd_tlast_i  in  1  search-device source last beat of packet.
- sd_tkeep_i  in  T_KEEP_WIDTH  search-device source byte enables.
- sd_trdy_o  out  1  search-device source ready.
- au_tdata_i, au_tvld_i, au_tlast_i, au_tkeep_i  in  same widths as sd  axi2udp source.
- au_trdy_o  out  1  axi2udp source ready.
- arp_tdata_i, arp_tvld_i, arp_tlast_i, arp_tkeep_i  in  same widths as sd  ARP source.
- arp_trdy_o  out  1  ARP source ready.
- to_tse_tdata_o  out  T_DATA_WIDTH  merged output data.
- to_tse_tvld_o  out  1  merged output valid.
- to_tse_tlast_o  out  1  merged output last beat.
- to_tse_tkeep_o  out  T_KEEP_WIDTH  merged output byte enables.
- to_tse_trdy_i  in  1  TSE ready.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=none, last_grant=ARP, so SD has first priority after reset.
  - All *_trdy_o=0.
  - to_tse_tvld_o=0, to_tse_tlast_o=0; tdata/tkeep=0.
- FSM, two states:
  - IDLE: sample tvld of all three sources. If any is high, register the grant and go to SEND.
    - Search order starts at last_grant+1, wrapping SD→AU→ARP→SD.
    - No source is accepted in IDLE; all trdy stay 0.
  - SEND: only the granted source's trdy = skid s_tready; the other two trdy=0.
    - The granted source's tdata/tlast/tkeep/tvld are muxed into the skid.
    - A beat is accepted when the granted source's tvld & trdy are both 1.
    - On an accepted beat with tlast=1: last_grant←grant, state←IDLE.
    - The granted source dropping tvld mid-packet keeps the grant; no beat is ever taken from another source until tlast.
- Latency and throughput:
  - Source tvld rises in IDLE → trdy high next cycle.
  - First beat appears on to_tse_tvld_o one cycle after acceptance, i.e. 2 cycles after the request.
  - Steady state: 1 beat/cycle with to_tse_trdy_i=1.
  - Exactly one idle cycle between consecutive packets (the IDLE arbitration cycle).
- Output stage is the skid buffer:
  - Depth 2, so a to_tse_trdy_i deassertion loses no beat.
  - to_tse_tvld_o, once high, holds with stable data until to_tse_trdy_i=1 (AXI-S rule).
  - tdata/tkeep/tlast pass through unmodified; no byte-enable checks.
- Simultaneous requests: resolved strictly by round-robin order; no source wins twice in a row while another requests.
- Single-beat packet (tvld & tlast on the first beat): accepted in the first SEND cycle, then straight back to IDLE.
- Reset mid-packet:
  - Truncated packet is discarded: the skid is cleared and no tlast is emitted.
  - The TSE is reset in the same domain, so no recovery framing is generated.
- No source ever sees trdy=1 while its tvld=0 is being interpreted as a request; trdy depends only on registered state and skid readiness.

Decomposition:
- Package umstr_pkg:
  - enum src_idx_t {SRC_SD, SRC_AU, SRC_ARP}.
  - merger state enum {ST_IDLE, ST_SEND}.
  - Localparam N_SRC=3.
- Sub-module: umstr_axis_skid (existing, parameterised T_DATA_WIDTH/T_KEEP_WIDTH) instantiated once as the output register.
- Arbiter, mux and FSM live in this module.

Test Plan:
- Single source: AU sends a 4-beat packet 0xA0..0xA3 with tlast on 0xA3 and to_tse_trdy_i=1 → output carries 0xA0..0xA3 in order; first to_tse_tvld_o 2 cycles after au_tvld_i rises; tlast only on 0xA3.
- Contention after reset: SD, AU and ARP all assert tvld on the same cycle, 2 beats each → packet order SD, AU, ARP, with one idle cycle between packets; no interleaved beats.
- Round-robin fairness: SD and ARP continuously request 1-beat packets → output alternates SD, ARP, SD, ARP; AU is never granted.
- Backpressure: to_tse_trdy_i toggles 1,0,0,1 during an 8-beat SD packet → all 8 beats arrive once, in order; tdata stable while tvld=1 and trdy=0.
- Mid-packet source stall: ARP drops tvld for 3 cycles after beat 2 of 5 while SD requests → beats 3..5 of ARP are still emitted before any SD beat; sd_trdy_o stays 0 throughout.
- Reset mid-operation: assert reset_n=0 during beat 3 of an AU packet → all trdy and to_tse_tvld_o go to 0 immediately; after release, SD is granted first when all three sources request.

Source files
------------

// File: rtl/umstr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | umstr_pkg : shared types for the transmit stream merger. Rev 1.0 |
// +------------------------------------------------------------------+
package umstr_pkg;

  localparam int N_SRC = 3;

  typedef enum logic [1:0] {
    SRC_SD  = 2'd0,
    SRC_AU  = 2'd1,
    SRC_ARP = 2'd2
  } src_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } merger_state_t;

  function automatic src_idx_t rr_next(input src_idx_t cur);
    src_idx_t nxt;
    case (cur)
      SRC_SD:  nxt = SRC_AU;
      SRC_AU:  nxt = SRC_ARP;
      default: nxt = SRC_SD;
    endcase
    return nxt;
  endfunction

  // First requester after 'last' in SD->AU->ARP order; 'last' itself is tried last.
  function automatic src_idx_t rr_pick(input src_idx_t last, input logic [N_SRC-1:0] req);
    src_idx_t cand;
    src_idx_t pick;
    logic     found;
    cand  = last;
    pick  = last;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = rr_next(cand);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage : umstr_pkg
`default_nettype wire

// File: rtl/umstr_axis_skid.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | umstr_axis_skid : registered 2-deep AXI-Stream skid. Rev 1.0     |
// +------------------------------------------------------------------+
module umstr_axis_skid #(
  parameter int T_DATA_WIDTH = 32,
  parameter int T_KEEP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [T_DATA_WIDTH-1:0] s_tdata_i,
  input  logic [T_KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic                    s_tlast_i,
  input  logic                    s_tvld_i,
  output logic                    s_trdy_o,
  output logic [T_DATA_WIDTH-1:0] m_tdata_o,
  output logic [T_KEEP_WIDTH-1:0] m_tkeep_o,
  output logic                    m_tlast_o,
  output logic                    m_tvld_o,
  input  logic                    m_trdy_i
);

  logic                    m_vld_q,  m_vld_d;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [T_KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                    m_last_q, m_last_d;
  logic                    sk_vld_q,  sk_vld_d;
  logic [T_DATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic [T_KEEP_WIDTH-1:0] sk_keep_q, sk_keep_d;
  logic                    sk_last_q, sk_last_d;
  logic                    accept;

  // Ready comes straight from a flop: the stage accepts whenever the skid slot is free.
  assign s_trdy_o = ~sk_vld_q;
  assign accept   = s_tvld_i & ~sk_vld_q;

  always_comb begin
    m_vld_d   = m_vld_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    sk_vld_d  = sk_vld_q;
    sk_data_d = sk_data_q;
    sk_keep_d = sk_keep_q;
    sk_last_d = sk_last_q;
    if (m_trdy_i || !m_vld_q) begin
      if (sk_vld_q) begin
        m_vld_d  = 1'b1;
        m_data_d = sk_data_q;
        m_keep_d = sk_keep_q;
        m_last_d = sk_last_q;
        sk_vld_d = 1'b0;
      end else begin
        m_vld_d = accept;
        if (accept) begin
          m_data_d = s_tdata_i;
          m_keep_d = s_tkeep_i;
          m_last_d = s_tlast_i;
        end
      end
    end else if (accept) begin
      // Output is stalled: park the in-flight beat so nothing is lost.
      sk_vld_d  = 1'b1;
      sk_data_d = s_tdata_i;
      sk_keep_d = s_tkeep_i;
      sk_last_d = s_tlast_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld_q   <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      sk_vld_q  <= 1'b0;
      sk_data_q <= '0;
      sk_keep_q <= '0;
      sk_last_q <= 1'b0;
    end else begin
      m_vld_q   <= m_vld_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      sk_vld_q  <= sk_vld_d;
      sk_data_q <= sk_data_d;
      sk_keep_q <= sk_keep_d;
      sk_last_q <= sk_last_d;
    end
  end

  assign m_tvld_o  = m_vld_q;
  assign m_tdata_o = m_data_q;
  assign m_tkeep_o = m_keep_q;
  assign m_tlast_o = m_last_q;

endmodule : umstr_axis_skid
`default_nettype wire

// File: rtl/umstr_st_merger.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | umstr_st_merger : packet round-robin merge of SD/AU/ARP to TSE.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module umstr_st_merger
  import umstr_pkg::*;
#(
  parameter int T_DATA_WIDTH = 32,
  parameter int T_KEEP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [T_DATA_WIDTH-1:0] sd_tdata_i,
  input  logic                    sd_tvld_i,
  input  logic                    sd_tlast_i,
  input  logic [T_KEEP_WIDTH-1:0] sd_tkeep_i,
  output logic                    sd_trdy_o,
  input  logic [T_DATA_WIDTH-1:0] au_tdata_i,
  input  logic                    au_tvld_i,
  input  logic                    au_tlast_i,
  input  logic [T_KEEP_WIDTH-1:0] au_tkeep_i,
  output logic                    au_trdy_o,
  input  logic [T_DATA_WIDTH-1:0] arp_tdata_i,
  input  logic                    arp_tvld_i,
  input  logic                    arp_tlast_i,
  input  logic [T_KEEP_WIDTH-1:0] arp_tkeep_i,
  output logic                    arp_trdy_o,
  output logic [T_DATA_WIDTH-1:0] to_tse_tdata_o,
  output logic                    to_tse_tvld_o,
  output logic                    to_tse_tlast_o,
  output logic [T_KEEP_WIDTH-1:0] to_tse_tkeep_o,
  input  logic                    to_tse_trdy_i
);

  logic [T_DATA_WIDTH-1:0] src_tdata [N_SRC];
  logic [T_KEEP_WIDTH-1:0] src_tkeep [N_SRC];
  logic [N_SRC-1:0]        src_tvld;
  logic [N_SRC-1:0]        src_tlast;
  logic [N_SRC-1:0]        src_trdy;

  merger_state_t state_q, state_d;
  src_idx_t      grant_q, grant_d;
  src_idx_t      last_grant_q, last_grant_d;

  logic [T_DATA_WIDTH-1:0] sel_tdata;
  logic [T_KEEP_WIDTH-1:0] sel_tkeep;
  logic                    sel_tlast;
  logic                    sel_tvld;
  logic                    skid_trdy;
  logic                    beat_fire;

  assign src_tdata[SRC_SD]  = sd_tdata_i;
  assign src_tdata[SRC_AU]  = au_tdata_i;
  assign src_tdata[SRC_ARP] = arp_tdata_i;
  assign src_tkeep[SRC_SD]  = sd_tkeep_i;
  assign src_tkeep[SRC_AU]  = au_tkeep_i;
  assign src_tkeep[SRC_ARP] = arp_tkeep_i;
  assign src_tvld           = {arp_tvld_i,  au_tvld_i,  sd_tvld_i};
  assign src_tlast          = {arp_tlast_i, au_tlast_i, sd_tlast_i};

  // Ready reaches a source only while it holds the grant; depends on flops only.
  for (genvar g = 0; g < N_SRC; g++) begin : g_trdy
    assign src_trdy[g] = (state_q == ST_SEND) && (grant_q == src_idx_t'(g)) && skid_trdy;
  end

  assign sd_trdy_o  = src_trdy[SRC_SD];
  assign au_trdy_o  = src_trdy[SRC_AU];
  assign arp_trdy_o = src_trdy[SRC_ARP];

  assign sel_tdata = src_tdata[grant_q];
  assign sel_tkeep = src_tkeep[grant_q];
  assign sel_tlast = src_tlast[grant_q];
  assign sel_tvld  = (state_q == ST_SEND) && src_tvld[grant_q];
  assign beat_fire = sel_tvld && skid_trdy;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|src_tvld) begin
          grant_d = rr_pick(last_grant_q, src_tvld);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_fire && sel_tlast) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_grant resets to ARP so the first search starts at SD; grant is unused in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= SRC_SD;
      last_grant_q <= SRC_ARP;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  umstr_axis_skid #(
    .T_DATA_WIDTH (T_DATA_WIDTH),
    .T_KEEP_WIDTH (T_KEEP_WIDTH)
  ) u_out_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tdata_i (sel_tdata),
    .s_tkeep_i (sel_tkeep),
    .s_tlast_i (sel_tlast),
    .s_tvld_i  (sel_tvld),
    .s_trdy_o  (skid_trdy),
    .m_tdata_o (to_tse_tdata_o),
    .m_tkeep_o (to_tse_tkeep_o),
    .m_tlast_o (to_tse_tlast_o),
    .m_tvld_o  (to_tse_tvld_o),
    .m_trdy_i  (to_tse_trdy_i)
  );

endmodule : umstr_st_merger
`default_nettype wire
